// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron threshold engine.
package neuron_pkg;
    localparam int DEF_DATA_W   = 10;
    localparam int DEF_REFRAC_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        RST_ABS    = 2'b00,
        RST_LINEAR = 2'b01,
        RST_NONE   = 2'b10
    } reset_mode_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/refrac_mem.sv
// Simple dual-port refractory counter RAM: synchronous read, one write port.
module refrac_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read returns the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/neuron_threshold_engine.sv
// Two-stage threshold/reset engine with per-neuron refractory counters.
// Optional macro STOCHASTIC_THR_EN adds LFSR noise to the positive threshold.
module neuron_threshold_engine
    import neuron_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_NEURONS = 256,
    parameter int ADDR_W    = $clog2(N_NEURONS),
    parameter int REFRAC_W  = DEF_REFRAC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_potential,
    input  logic [DATA_W-2:0]   in_pos_thr,
    input  logic [DATA_W-2:0]   in_neg_thr,
    input  logic [1:0]          in_thr_en,
    input  logic [1:0]          in_reset_mode,
    input  logic                in_neg_mode,
    input  logic [DATA_W-1:0]   in_v_reset,
    input  logic [REFRAC_W-1:0] in_refrac,
    input  logic                in_spike_en,
    input  logic [DATA_W-2:0]   in_thr_rand_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [DATA_W-1:0]   out_potential,
    output logic                out_spike,
    output logic [15:0]         spike_count
);
    localparam int TW = DATA_W - 1;
    localparam logic [DATA_W-1:0] V_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] V_MAX = ~V_MIN;

    logic                sweep_q;
    logic [ADDR_W-1:0]   sweep_addr_q;

    logic                s1_vld_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [DATA_W-1:0]   s1_v_q;
    logic [TW-1:0]       s1_alpha_q;
    logic [TW-1:0]       s1_beta_q;
    logic [1:0]          s1_thr_en_q;
    logic [1:0]          s1_mode_q;
    logic                s1_neg_mode_q;
    logic [DATA_W-1:0]   s1_v_reset_q;
    logic [REFRAC_W-1:0] s1_refrac_q;
    logic                s1_spike_en_q;
    logic                byp_hit_q;
    logic [REFRAC_W-1:0] byp_cnt_q;

    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [DATA_W-1:0]   out_pot_q;
    logic                out_spike_q;
    logic [15:0]         spike_cnt_q;

    logic                adv;
    logic                accept;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [REFRAC_W-1:0] mem_wdata;
    logic [REFRAC_W-1:0] mem_rdata;

    logic [REFRAC_W-1:0] cnt;
    logic [REFRAC_W-1:0] cnt_d;
    logic [TW-1:0]       alpha_eff;
    logic signed [DATA_W:0] v_x, alpha_x, beta_x, neg_beta_x, diff_x;
    logic [DATA_W-1:0]   neg_vr;
    logic [DATA_W-1:0]   pot_d;
    logic                spike_d;

    assign adv      = !out_valid_q | out_ready;
    assign in_ready = adv & !sweep_q;
    assign accept   = in_valid & in_ready;

    // The sweep owns the write port while it runs; the pipeline is empty then.
    assign mem_we    = sweep_q | (adv & s1_vld_q);
    assign mem_waddr = sweep_q ? sweep_addr_q : s1_addr_q;
    assign mem_wdata = sweep_q ? '0 : cnt_d;

    refrac_mem #(
        .DEPTH (N_NEURONS),
        .AW    (ADDR_W),
        .DW    (REFRAC_W)
    ) u_mem (
        .clk     (clk),
        .re_i    (adv),
        .raddr_i (in_addr),
        .rdata_o (mem_rdata),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata)
    );

`ifdef STOCHASTIC_THR_EN
    logic [15:0]   lfsr_q;
    logic [TW-1:0] s1_noise_q;
    logic [TW:0]   alpha_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= LFSR_SEED;
            s1_noise_q <= '0;
        end else if (accept) begin
            lfsr_q     <= lfsr_next(lfsr_q);
            s1_noise_q <= lfsr_q[TW-1:0] & in_thr_rand_mask;
        end
    end

    assign alpha_sum = {1'b0, s1_alpha_q} + {1'b0, s1_noise_q};
    assign alpha_eff = alpha_sum[TW] ? '1 : alpha_sum[TW-1:0];
`else
    logic unused_mask;
    assign unused_mask = ^in_thr_rand_mask;
    assign alpha_eff   = s1_alpha_q;
`endif

    // Bypass covers the write that S2 performed on the same edge S1 read.
    assign cnt        = byp_hit_q ? byp_cnt_q : mem_rdata;
    assign v_x        = {s1_v_q[DATA_W-1], s1_v_q};
    assign alpha_x    = {2'b00, alpha_eff};
    assign beta_x     = {2'b00, s1_beta_q};
    assign neg_beta_x = -beta_x;
    assign diff_x     = v_x - alpha_x;
    assign neg_vr     = (s1_v_reset_q == V_MIN) ? V_MAX : -s1_v_reset_q;

    always_comb begin
        pot_d   = s1_v_q;
        spike_d = 1'b0;
        cnt_d   = cnt;
        if (cnt != '0) begin
            pot_d = s1_v_reset_q;
            cnt_d = cnt - REFRAC_W'(1);
        end else if (s1_thr_en_q[0] && (v_x >= alpha_x)) begin
            spike_d = s1_spike_en_q;
            cnt_d   = s1_refrac_q;
            case (s1_mode_q)
                RST_LINEAR: pot_d = diff_x[DATA_W-1:0];
                RST_NONE:   pot_d = s1_v_q;
                default:    pot_d = s1_v_reset_q;
            endcase
        end else if (s1_thr_en_q[1] && (v_x < neg_beta_x)) begin
            pot_d = s1_neg_mode_q ? neg_vr : neg_beta_x[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_q       <= 1'b1;
            sweep_addr_q  <= '0;
            s1_vld_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_v_q        <= '0;
            s1_alpha_q    <= '0;
            s1_beta_q     <= '0;
            s1_thr_en_q   <= '0;
            s1_mode_q     <= '0;
            s1_neg_mode_q <= 1'b0;
            s1_v_reset_q  <= '0;
            s1_refrac_q   <= '0;
            s1_spike_en_q <= 1'b0;
            byp_hit_q     <= 1'b0;
            byp_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_pot_q     <= '0;
            out_spike_q   <= 1'b0;
            spike_cnt_q   <= '0;
        end else begin
            if (sweep_q) begin
                sweep_addr_q <= sweep_addr_q + ADDR_W'(1);
                if (sweep_addr_q == ADDR_W'(N_NEURONS - 1)) sweep_q <= 1'b0;
            end
            if (adv) begin
                s1_vld_q <= accept;
                if (accept) begin
                    s1_addr_q     <= in_addr;
                    s1_v_q        <= in_potential;
                    s1_alpha_q    <= in_pos_thr;
                    s1_beta_q     <= in_neg_thr;
                    s1_thr_en_q   <= in_thr_en;
                    s1_mode_q     <= in_reset_mode;
                    s1_neg_mode_q <= in_neg_mode;
                    s1_v_reset_q  <= in_v_reset;
                    s1_refrac_q   <= in_refrac;
                    s1_spike_en_q <= in_spike_en;
                    byp_hit_q     <= mem_we && (mem_waddr == in_addr);
                    byp_cnt_q     <= mem_wdata;
                end
                out_valid_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_addr_q  <= s1_addr_q;
                    out_pot_q   <= pot_d;
                    out_spike_q <= spike_d;
                end
            end
            if (out_valid_q && out_ready && out_spike_q && (spike_cnt_q != 16'hFFFF))
                spike_cnt_q <= spike_cnt_q + 16'd1;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_potential = out_pot_q;
    assign out_spike     = out_spike_q;
    assign spike_count   = spike_cnt_q;
endmodule

// File: tb/tb_neuron_threshold_engine.sv
// Directed bench for neuron_threshold_engine (default build) with an
// integer behavioural model and a negedge compare process.
module tb_neuron_threshold_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_addr = '0;
    logic [9:0] in_potential = '0;
    logic [8:0] in_pos_thr = '0;
    logic [8:0] in_neg_thr = '0;
    logic [1:0] in_thr_en = '0;
    logic [1:0] in_reset_mode = '0;
    logic       in_neg_mode = 1'b0;
    logic [9:0] in_v_reset = '0;
    logic [3:0] in_refrac = '0;
    logic       in_spike_en = 1'b0;
    logic [8:0] in_thr_rand_mask = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_addr;
    logic [9:0] out_potential;
    logic       out_spike;
    logic [15:0] spike_count;

    neuron_threshold_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_potential(in_potential), .in_pos_thr(in_pos_thr),
        .in_neg_thr(in_neg_thr), .in_thr_en(in_thr_en), .in_reset_mode(in_reset_mode),
        .in_neg_mode(in_neg_mode), .in_v_reset(in_v_reset), .in_refrac(in_refrac),
        .in_spike_en(in_spike_en), .in_thr_rand_mask(in_thr_rand_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_potential(out_potential), .out_spike(out_spike), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit started = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int addr; int pot; bit spk;
        bit has_lit; int lit_pot; bit lit_spk;
    } exp_t;

    exp_t eq[$];
    int   refr[256];
    int   mc = 0;
    bit   lit_has = 0;
    int   lit_pot = 0;
    bit   lit_spk = 0;

    function automatic exp_t model_beat();
        exp_t e;
        int v, a, b, vr, c;
        v  = $signed(in_potential);
        a  = in_pos_thr;
        b  = in_neg_thr;
        vr = $signed(in_v_reset);
        c  = refr[in_addr];
        e.addr = in_addr; e.spk = 0; e.pot = v;
        if (c > 0) begin
            e.pot = vr;
            refr[in_addr] = c - 1;
        end else if (in_thr_en[0] && v >= a) begin
            e.spk = in_spike_en;
            refr[in_addr] = in_refrac;
            if (in_reset_mode == 2'b01) e.pot = v - a;
            else if (in_reset_mode == 2'b10) e.pot = v;
            else e.pot = vr;
        end else if (in_thr_en[1] && v < -b) begin
            if (in_neg_mode) e.pot = (vr == -512) ? 511 : -vr;
            else e.pot = -b;
        end
        e.has_lit = lit_has; e.lit_pot = lit_pot; e.lit_spk = lit_spk;
        return e;
    endfunction

    logic [19:0] prev_out = '0;
    bit          stall_prev = 0;

    always @(negedge clk) begin
        exp_t e;
        logic [19:0] cur;
        cur = {out_valid, out_addr, out_potential, out_spike};
        if (started) begin
            chk("spike_count", spike_count, mc);
            if (stall_prev && !rst) chk("hold_stable", cur, prev_out);
        end
        if (rst) begin
            eq.delete();
            foreach (refr[i]) refr[i] = 0;
            mc = 0;
            stall_prev = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (eq.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = eq.pop_front();
                    chk("out_addr", out_addr, e.addr);
                    chk("out_pot", $signed(out_potential), e.pot);
                    chk("out_spike", out_spike, e.spk);
                    if (e.has_lit) begin
                        chk("model_lit_pot", e.pot, e.lit_pot);
                        chk("model_lit_spk", e.spk, e.lit_spk);
                    end
                    if (e.spk && mc < 65535) mc++;
                end
            end
            if (in_valid && in_ready) eq.push_back(model_beat());
            stall_prev = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int addr, input int v, input int alpha, input int beta,
                        input int en, input int mode, input int negm, input int vr,
                        input int rf, input int sen, input int lpot, input int lspk);
        bit acc;
        in_addr = 8'(addr); in_potential = 10'(v); in_pos_thr = 9'(alpha);
        in_neg_thr = 9'(beta); in_thr_en = 2'(en); in_reset_mode = 2'(mode);
        in_neg_mode = negm[0]; in_v_reset = 10'(vr); in_refrac = 4'(rf);
        in_spike_en = sen[0]; in_thr_rand_mask = 9'h1A5;
        lit_has = 1; lit_pot = lpot; lit_spk = lspk[0];
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lit_has = 0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic lat_check(input int epot, input int espk);
        @(negedge clk); chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk); chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_pot", $signed(out_potential), epot);
        chk("lat_spike", out_spike, espk);
        @(posedge clk); #1;
    endtask

    task automatic count_check(input string name, input int exp);
        @(negedge clk); chk(name, spike_count, exp);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        started = 1;
    endtask

    task automatic sweep_check();
        int low = 0;
        bit first = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (first) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_out_pot", out_potential, 0);
                chk("rst_out_spike", out_spike, 0);
                chk("rst_spike_count", spike_count, 0);
                first = 0;
            end
            if (in_ready) break;
            low++;
        end
        chk("sweep_len", low, 256);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (eq.size() == 0) && !out_valid;
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        // reset and sweep
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        started = 1;
        sweep_check();

        // absolute reset
        send(1, 300, 200, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        lat_check(0, 1);
        count_check("count_after_abs", 1);

        // linear reset then sub-threshold on same neuron
        send(2, 300, 200, 0, 1, 1, 0, 0, 0, 1, 100, 1);
        lat_check(100, 1);
        send(2, 150, 200, 0, 1, 1, 0, 0, 0, 1, 150, 0);
        lat_check(150, 0);

        // refractory with back-to-back bypass
        send(5, 500, 200, 0, 1, 0, 0, 7, 3, 1, 7, 1);
        for (int k = 0; k < 3; k++) send(5, 500, 200, 0, 1, 0, 0, 7, 3, 1, 7, 0);
        send(5, 500, 200, 0, 1, 0, 0, 7, 3, 1, 7, 1);
        drain();
        count_check("count_after_refrac", 4);

        // negative floor and comparison boundaries
        send(9, -300, 0, 100, 2, 0, 0, 0, 0, 1, -100, 0);
        send(10, -300, 0, 100, 2, 0, 1, 20, 0, 1, -20, 0);
        send(11, -300, 0, 100, 2, 0, 1, -512, 0, 1, 511, 0);
        send(12, -100, 0, 100, 2, 0, 0, 0, 0, 1, -100, 0);
        send(13, 200, 200, 0, 1, 2, 0, 0, 0, 1, 200, 1);
        send(13, 199, 200, 0, 1, 2, 0, 0, 0, 1, 199, 0);
        send(14, 300, 100, 0, 3, 3, 0, -5, 0, 1, -5, 1);
        send(15, 500, 100, 100, 0, 0, 0, 3, 2, 1, 500, 0);
        drain();
        count_check("count_after_neg", 6);

        // backpressure with spike suppressed
        out_ready = 1'b0;
        send(16, 300, 200, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        send(17, 10, 200, 0, 1, 0, 0, 0, 0, 1, 10, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_spike", out_spike, 0);
            chk("stall_out_pot", $signed(out_potential), 0);
            chk("stall_count", spike_count, 6);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        count_check("count_after_stall", 6);

        // reset mid-stream drops in-flight beats and clears counters
        send(20, 300, 200, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        send(21, 10, 200, 0, 1, 0, 0, 0, 0, 1, 10, 0);
        do_reset();
        sweep_check();
        send(5, 500, 200, 0, 1, 0, 0, 7, 3, 1, 7, 1);
        lat_check(7, 1);
        count_check("count_after_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_threshold_engine.md
Name: neuron_threshold_engine

Overview:
- Time-multiplexed threshold/reset engine for a core of N_NEURONS neurons.
- Accepts one integrated membrane potential per cycle over a valid/ready stream.
- Applies per-neuron positive/negative thresholds, a selectable reset mode and a per-neuron refractory counter kept in internal memory.
- Emits the post-reset potential plus a spike flag, and sits between the synaptic integrator and the spike router.

Parameters:
- DATA_W, 10, signed membrane potential width (two's complement).
- N_NEURONS, 256, neurons per core; sizes the refractory memory.
- ADDR_W, $clog2(N_NEURONS), neuron address width.
- REFRAC_W, 4, refractory counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat
- in_addr  in  ADDR_W  neuron index
- in_potential  in  DATA_W  signed integrated potential V
- in_pos_thr  in  DATA_W-1  unsigned positive threshold alpha
- in_neg_thr  in  DATA_W-1  unsigned negative threshold magnitude beta
- in_thr_en  in  2  bit0 positive check enable, bit1 negative check enable
- in_reset_mode  in  2  00 absolute, 01 linear, 10 none, 11 reserved (treated as 00)
- in_neg_mode  in  1  0 saturate at -beta, 1 reset to -v_reset
- in_v_reset  in  DATA_W  signed reset potential
- in_refrac  in  REFRAC_W  refractory period loaded on spike
- in_spike_en  in  1  0 suppresses spike output; the reset still applies
- in_thr_rand_mask  in  DATA_W-1  threshold noise mask
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_addr  out  ADDR_W  neuron index
- out_potential  out  DATA_W  post-reset potential
- out_spike  out  1  spike fired
- spike_count  out  16  total spikes since reset, saturating

Behaviour:
- Reset is synchronous and active-high; it uses port rst, clocked on clk.
- Reset values:
  - out_valid=0, out_addr=0, out_potential=0, out_spike=0, spike_count=0.
  - All refractory counters cleared to 0, via a sweep of N_NEURONS cycles.
  - in_ready=0 during the sweep.
- Pipeline:
  - Two stages. S1 reads the refractory memory and registers the inputs. S2 decides, writes back and drives the outputs.
  - Latency is 2 cycles from accepted beat to out_valid.
  - adv = !out_valid | out_ready; in_ready = adv & !sweeping.
  - Both stages hold when adv=0.
  - Outputs stay stable while out_valid & !out_ready.
- Hazard: a same-address beat in S1 while S2 writes the counter must use the S2 write value (bypass). Back-to-back same address must behave as if serialised.
- Decision, in priority order, with cnt = stored refractory value:
  1. cnt != 0: no spike, out_potential = v_reset, cnt <= cnt - 1.
  2. thr_en[0] & V >= alpha: spike = spike_en, cnt <= in_refrac.
     - Mode 00: out_potential = v_reset.
     - Mode 01: out_potential = V - alpha. This is non-negative, so no saturation is needed.
     - Mode 10: out_potential = V.
  3. thr_en[1] & V < -beta: no spike.
     - neg_mode 0: out_potential = -beta.
     - neg_mode 1: out_potential = -v_reset. If v_reset is the most negative value, the negation saturates to the most positive value.
  4. Otherwise: out_potential = V, cnt unchanged.
- Comparisons are signed, with alpha and beta zero-extended to DATA_W+1 bits.
- spike_count increments when the out_spike handshake completes (out_valid & out_ready & out_spike), and saturates at 0xFFFF.
- rst asserted mid-stream: in-flight beats are dropped, out_valid=0 on the next cycle, and the sweep restarts.

Optional Feature:
- Macro STOCHASTIC_THR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) advances on every accepted beat.
  - Effective alpha = alpha + (lfsr[DATA_W-2:0] & in_thr_rand_mask), saturating at the maximum unsigned value.
  - Linear mode subtracts the effective alpha.
- Undefined: in_thr_rand_mask is ignored, there is no LFSR, and the threshold is deterministic.

Decomposition:
- Package neuron_pkg holds:
  - reset_mode_t enum (RST_ABS, RST_LINEAR, RST_NONE).
  - Default widths DATA_W/REFRAC_W.
  - LFSR seed and taps constant.
- One sub-module, refrac_mem: a simple dual-port RAM, N_NEURONS x REFRAC_W, with synchronous read and one write port. The sweep clear is driven from the parent.

Test Plan:
- Reset sweep: hold rst 1 cycle, N_NEURONS=256 → in_ready low for 256 cycles, then high; all outputs 0.
- Absolute reset: V=300, alpha=200, v_reset=0, mode 00, refrac 0 → out_potential=0, out_spike=1, 2-cycle latency, spike_count=1.
- Linear reset: V=300, alpha=200, mode 01 → out_potential=100, spike=1. Same neuron next beat, V=150 → no spike, potential 150.
- Refractory: addr 5 spikes with refrac=3, then three back-to-back beats to addr 5 with V=500 → no spike, potential=v_reset, bypass exercised. Fourth beat spikes.
- Negative floor: V=-300, beta=100, thr_en=10, neg_mode 0 → -100. neg_mode 1, v_reset=20 → -20.
- Backpressure and mask: out_ready low 5 cycles with spike_en=0 on a crossing beat → outputs held stable, in_ready low, out_spike=0, spike_count unchanged, potential reset applied.
